vector_element_sequencer: RTL

// - Sits directly downstream of vector decode: consumes one decoded vector op (vl, vstart, sew, vd/vs1/vs2)
//   and walks its element range, issuing NUM_LANES consecutive elements per beat to the lane datapath.
// - Per beat it produces the element base index, per-lane enables, the physical register within each

---
 rtl/vector_element_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/vector_element_sequencer.sv
// Vector element sequencer: walks [vstart, vl) of one decoded vector op, NUM_LANES elements per beat.
// Optional VSEQ_MASK_EN adds in_vm/in_mask, which gate lane enables with the v0 mask.
module vector_element_sequencer #(
  parameter int NUM_LANES = 2,
  parameter int VLEN      = 128,
  parameter int VL_W      = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [VL_W-1:0]      in_vl,
  input  logic [VL_W-1:0]      in_vstart,
  input  logic [2:0]           in_sew,
  input  logic [4:0]           in_vd,
  input  logic [4:0]           in_vs1,
  input  logic [4:0]           in_vs2,
`ifdef VSEQ_MASK_EN
  input  logic                 in_vm,
  input  logic [VLEN-1:0]      in_mask,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [VL_W-1:0]      out_elem_base,
  output logic [NUM_LANES-1:0] out_lane_en,
  output logic [4:0]           out_vd,
  output logic [4:0]           out_vs1,
  output logic [4:0]           out_vs2,
  output logic [3:0]           out_byte_off,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal
);

  localparam int IDX_W = VL_W + 1;
  localparam logic [3:0] LOG2_VLENB = 4'($clog2(VLEN / 8));

  typedef enum logic [2:0] {SEW8 = 3'd0, SEW16 = 3'd1, SEW32 = 3'd2, SEW64 = 3'd3} sew_e;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] base_q, base_d;
  logic [IDX_W-1:0] vl_q, vl_d;
  logic [2:0]       sew_q, sew_d;
  logic [4:0]       vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;
`ifdef VSEQ_MASK_EN
  logic             vm_q, vm_d;
  logic [VLEN-1:0]  mask_q, mask_d;
`endif

  logic             run;
  logic             last_beat;
  logic [3:0]       elem_shift;
  logic [IDX_W-1:0] epr_m1;
  logic [4:0]       reg_off;

  assign run        = (state_q == RUN);
  // Base index is one bit wider than vl so base+NUM_LANES never wraps on the final beat.
  assign last_beat  = (base_q + IDX_W'(NUM_LANES)) >= vl_q;
  // log2(elements per register) = log2(VLENB) - sew
  assign elem_shift = LOG2_VLENB - {1'b0, sew_q};
  assign epr_m1     = (IDX_W'(1) << elem_shift) - IDX_W'(1);
  assign reg_off    = 5'(base_q >> elem_shift);

  // NOTE: next-state logic is combinational; every *_d gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    vl_d      = vl_q;
    sew_d     = sew_q;
    vd_d      = vd_q;
    vs1_d     = vs1_q;
    vs2_d     = vs2_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
`ifdef VSEQ_MASK_EN
    vm_d      = vm_q;
    mask_d    = mask_q;
`endif
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            base_d = {1'b0, in_vstart};
            vl_d   = {1'b0, in_vl};
            sew_d  = in_sew;
            vd_d   = in_vd;
            vs1_d  = in_vs1;
            vs2_d  = in_vs2;
`ifdef VSEQ_MASK_EN
            vm_d   = in_vm;
            mask_d = in_mask;
`endif
            if (in_sew >= SEW64)          illegal_d = 1'b1;
            else if (in_vstart >= in_vl)  done_d    = 1'b1;
            else                          state_d   = RUN;
          end
        end
        RUN: begin
          if (out_ready) begin
            if (last_beat) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              base_d = base_q + IDX_W'(NUM_LANES);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      base_q    <= '0;
      vl_q      <= '0;
      sew_q     <= '0;
      vd_q      <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef VSEQ_MASK_EN
      vm_q      <= 1'b1;
      mask_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      vl_q      <= vl_d;
      sew_q     <= sew_d;
      vd_q      <= vd_d;
      vs1_q     <= vs1_d;
      vs2_q     <= vs2_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
`ifdef VSEQ_MASK_EN
      vm_q      <= vm_d;
      mask_q    <= mask_d;
`endif
    end
  end

  always_comb begin
    logic [IDX_W-1:0] idx;
    idx         = '0;
    out_lane_en = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx            = base_q + IDX_W'(i);
      out_lane_en[i] = run && (idx < vl_q);
`ifdef VSEQ_MASK_EN
      if (!vm_q)
        out_lane_en[i] = out_lane_en[i] && (idx < IDX_W'(VLEN)) && mask_q[idx[$clog2(VLEN)-1:0]];
`endif
    end
  end

  // All beat fields come straight from flops, so they hold still while the lanes stall.
  assign in_ready      = !run;
  assign out_valid     = run;
  assign busy          = run;
  assign done          = done_q;
  assign illegal       = illegal_q;
  assign out_last      = run && last_beat;
  assign out_elem_base = base_q[VL_W-1:0];
  assign out_vd        = vd_q + reg_off;
  assign out_vs1       = vs1_q + reg_off;
  assign out_vs2       = vs2_q + reg_off;
  assign out_byte_off  = 4'((base_q & epr_m1) << sew_q);

endmodule
